pipe_addsub: RTL and testbench

//   Parametrised, pipelined add/subtract unit; next generation of the team's 8-bit ripple full adder.

---
 rtl/pipe_addsub_if.sv | 26 ++
 rtl/pipe_addsub.sv | 115 +++++++++++
 tb/tb_pipe_addsub.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result bundle for the segmented add/subtract pipeline.
// The producer drives operands and hold through the master modport; the pipeline uses slave.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             hold;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output hold, in_valid, a, b, cin, sub,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  hold, in_valid, a, b, cin, sub,
    output out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented add/subtract: the WIDTH-bit carry chain is cut into SEG-bit slices, one register stage each.
// Operands not yet consumed ride along in skew registers, shifted down so the next slice is always at bit 0.
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_addsub_if.slave bus
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           c);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
  endfunction

  // Stage inputs: element 0 is the prepared operand set, element k>0 is stage k-1's register.
  word_t             a_in   [STAGES];
  word_t             bx_in  [STAGES];
  word_t             res_in [STAGES];
  logic [STAGES-1:0] cy_in;
  logic [STAGES-1:0] am_in;
  logic [STAGES-1:0] bm_in;
  logic [STAGES-1:0] vld_in;

  logic [SEG:0]      seg_s  [STAGES];
  word_t             a_n    [STAGES];
  word_t             bx_n   [STAGES];
  word_t             res_n  [STAGES];
  logic [STAGES-1:0] cy_n;

  word_t             a_p    [STAGES];
  word_t             bx_p   [STAGES];
  word_t             res_p  [STAGES];
  logic [STAGES-1:0] cy_p;
  logic [STAGES-1:0] am_p;
  logic [STAGES-1:0] bm_p;
  logic [STAGES-1:0] vld_p;

  // Operand preparation in front of stage 0
  always_comb begin
    a_in[0]   = bus.a;
    bx_in[0]  = bus.sub ? ~bus.b : bus.b;
    res_in[0] = '0;
    cy_in[0]  = bus.sub ? 1'b1 : bus.cin;
    am_in[0]  = bus.a[WIDTH-1];
    bm_in[0]  = bx_in[0][WIDTH-1];
    vld_in[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_p[k-1];
      bx_in[k]  = bx_p[k-1];
      res_in[k] = res_p[k-1];
      cy_in[k]  = cy_p[k-1];
      am_in[k]  = am_p[k-1];
      bm_in[k]  = bm_p[k-1];
      vld_in[k] = vld_p[k-1];
    end
  end

  // Per-stage slice add; result bits above the current slice are still zero, so OR merges it in.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_s[k] = seg_add(a_in[k][SEG-1:0], bx_in[k][SEG-1:0], cy_in[k]);
      res_n[k] = res_in[k] | (word_t'(seg_s[k][SEG-1:0]) << (k * SEG));
      cy_n[k]  = seg_s[k][SEG];
      a_n[k]   = a_in[k] >> SEG;
      bx_n[k]  = bx_in[k] >> SEG;
    end
  end

  // Stage registers; the final stage doubles as the output register and only loads on a valid slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p       <= '0;
      res_p[LAST] <= '0;
      cy_p[LAST]  <= 1'b0;
      am_p[LAST]  <= 1'b0;
      bm_p[LAST]  <= 1'b0;
    end else if (!bus.hold) begin
      vld_p <= vld_in;
      for (int k = 0; k < LAST; k++) begin
        res_p[k] <= res_n[k];
        cy_p[k]  <= cy_n[k];
        am_p[k]  <= am_in[k];
        bm_p[k]  <= bm_in[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]  <= a_n[k];
        bx_p[k] <= bx_n[k];
      end
      if (vld_in[LAST]) begin
        res_p[LAST] <= res_n[LAST];
        cy_p[LAST]  <= cy_n[LAST];
        am_p[LAST]  <= am_in[LAST];
        bm_p[LAST]  <= bm_in[LAST];
      end
    end
  end

  // The last stage's skew registers are always empty after the final shift
  logic unused_skew;
  assign unused_skew = ^{a_p[LAST], bx_p[LAST]};

  assign bus.out_valid = vld_p[LAST];
  assign bus.sum       = res_p[LAST];
  assign bus.cout      = cy_p[LAST];
  assign bus.ovf       = (am_p[LAST] == bm_p[LAST]) && (res_p[LAST][WIDTH-1] != am_p[LAST]);

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: a 32/8 instance against a latency-line reference model, plus an 8/8 instance swept directly.
module tb_pipe_addsub;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  logic run;
  logic cnt_en;
  int   checks;
  int   failures;
  int   vcount;

  pipe_addsub_if #(.WIDTH(32)) bus ();
  pipe_addsub_if #(.WIDTH(8))  bus8 ();

  pipe_addsub #(.WIDTH(32), .SEG(8)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_addsub #(.WIDTH(8),  .SEG(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: {ovf, cout, sum} from integer rules of add/subtract in w bits.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic s, input int w);
    longint m, h, ua, ub, sa, sb, t, r;
    logic [31:0] sv;
    logic co, ov;
    m  = longint'(1) << w;
    h  = m / 2;
    ua = longint'({32'b0, a}) & (m - 1);
    ub = longint'({32'b0, b}) & (m - 1);
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    if (s) begin
      t  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      t  = ua + ub + longint'({63'b0, c});
      co = (t >= m);
      r  = sa + sb + longint'({63'b0, c});
    end
    ov = (r < -h) || (r >= h);
    t  = t & (m - 1);
    sv = t[31:0];
    return {ov, co, sv};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference latency line: an accepted op appears LAT enabled edges later; outputs hold otherwise.
  typedef struct packed {
    logic        v;
    logic        o;
    logic        c;
    logic [31:0] s;
  } slot_t;

  slot_t       new_slot;
  slot_t       pm [LAT-1];
  logic        exp_v;
  logic [31:0] exp_s;
  logic        exp_c;
  logic        exp_o;

  always_comb begin
    new_slot   = '0;
    new_slot.v = bus.in_valid;
    {new_slot.o, new_slot.c, new_slot.s} = ref_op(bus.a, bus.b, bus.cin, bus.sub, 32);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT - 1; k++) pm[k] <= '0;
      exp_v <= 1'b0;
      exp_s <= '0;
      exp_c <= 1'b0;
      exp_o <= 1'b0;
    end else if (!bus.hold) begin
      pm[0] <= new_slot;
      for (int k = 1; k < LAT - 1; k++) pm[k] <= pm[k-1];
      exp_v <= pm[LAT-2].v;
      if (pm[LAT-2].v) begin
        exp_s <= pm[LAT-2].s;
        exp_c <= pm[LAT-2].c;
        exp_o <= pm[LAT-2].o;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
      chk("sum",       64'(bus.sum),       64'(exp_s));
      chk("cout",      64'(bus.cout),      64'(exp_c));
      chk("ovf",       64'(bus.ovf),       64'(exp_o));
    end
  end

  always @(negedge clk) begin
    if (cnt_en && bus.out_valid) vcount++;
  end

  task automatic set32(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.sub      = s;
    bus.in_valid = 1'b1;
  endtask

  // Single op with literal expectations; latency counted in negedges after the sampling edge.
  task automatic lit32(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s,
                       input logic [31:0] es, input logic ec, input logic eo);
    int n;
    set32(a, b, c, s);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n),        64'(LAT));
    chk({nm, "_sum"},     64'(bus.sum),  64'(es));
    chk({nm, "_cout"},    64'(bus.cout), 64'(ec));
    chk({nm, "_ovf"},     64'(bus.ovf),  64'(eo));
    repeat (6) @(negedge clk);
  endtask

  logic [33:0] e8;
  int          n8;

  initial begin
    checks   = 0;
    failures = 0;
    vcount   = 0;
    run      = 1'b0;
    cnt_en   = 1'b0;
    rst_n    = 1'b0;
    bus.hold = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus8.hold = 1'b0; bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;

    // Model pins against hand-computed values
    chk("pin_wrap",  64'(ref_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32)), 64'({1'b0, 1'b1, 32'h0}));
    chk("pin_ovf",   64'(ref_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32)), 64'({1'b1, 1'b0, 32'h8000_0000}));
    chk("pin_sub",   64'(ref_op(32'd5, 32'd10, 1'b1, 1'b1, 32)),         64'({1'b0, 1'b0, 32'hFFFF_FFFB}));
    chk("pin_cin",   64'(ref_op(32'd255, 32'd1, 1'b1, 1'b0, 32)),        64'({1'b0, 1'b0, 32'd257}));
    chk("pin_w8",    64'(ref_op(32'd255, 32'd1, 1'b1, 1'b0, 8)),         64'({1'b0, 1'b1, 32'h01}));

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sum",       64'(bus.sum),       64'(0));
    chk("rst_cout",      64'(bus.cout),      64'(0));
    chk("rst_ovf",       64'(bus.ovf),       64'(0));
    chk("rst8_state",    64'({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum}), 64'(0));
    rst_n = 1'b1;
    run   = 1'b1;
    repeat (2) @(negedge clk);

    lit32("wrap",    32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    lit32("sovf_p",  32'h7FFF_FFFF, 32'd1,          1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    lit32("sovf_n",  32'h8000_0000, 32'h8000_0000,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1);
    lit32("sub_pos", 32'd100,       32'd55,         1'b0, 1'b1, 32'd45,        1'b1, 1'b0);
    lit32("sub_neg", 32'd5,         32'd10,         1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0);
    lit32("sub_cin", 32'd5,         32'd10,         1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0);

    // Stream of six ops with a two-cycle hold while the first result is presented
    vcount = 0;
    cnt_en = 1'b1;
    set32(32'd15,  32'd10,  1'b0, 1'b0); @(negedge clk);
    set32(32'd0,   32'd10,  1'b0, 1'b0); @(negedge clk);
    set32(32'd255, 32'd1,   1'b1, 1'b0); @(negedge clk);
    set32(32'd128, 32'd128, 1'b1, 1'b0); @(negedge clk);
    set32(pick32(), pick32(), 1'b0, 1'b0);
    bus.hold = 1'b1;
    repeat (2) @(negedge clk);
    bus.hold = 1'b0;
    @(negedge clk);
    set32(32'd7, 32'd3, 1'b0, 1'b1); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    cnt_en = 1'b0;
    chk("stream_valid_cycles", 64'(vcount), 64'(8));

    // Reset with ops in flight and a result on the output, hold asserted alongside
    for (int i = 0; i < 4; i++) begin
      set32(pick32(), pick32(), 1'(i), 1'b0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    #2;
    rst_n    = 1'b0;
    bus.hold = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_async_sum",   64'(bus.sum),       64'(0));
    @(negedge clk);
    #2;
    rst_n    = 1'b1;
    bus.hold = 1'b0;
    repeat (8) @(negedge clk);
    lit32("post_rst", 32'd1000, 32'd24, 1'b0, 1'b0, 32'd1024, 1'b0, 1'b0);

    // Random traffic with bubbles and holds
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.hold     = ($urandom_range(0, 7) == 0);
      bus.a        = pick32();
      bus.b        = pick32();
      bus.cin      = 1'($urandom_range(0, 1));
      bus.sub      = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    repeat (8) @(negedge clk);

    // Single-stage instance: literal case, then a sweep with latency 1
    bus8.a = 8'd255; bus8.b = 8'd1; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_lit", 64'({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum}), 64'({1'b1, 1'b0, 1'b1, 8'h01}));
    n8 = 0;
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib += 3) begin
        bus8.a   = 8'(ia);
        bus8.b   = 8'(ib);
        bus8.cin = 1'(n8);
        bus8.sub = 1'(n8 >> 1);
        e8 = ref_op(32'(ia), 32'(ib), bus8.cin, bus8.sub, 8);
        n8++;
        @(posedge clk);
        #1;
        chk("w8_sweep", 64'({bus8.out_valid, bus8.ovf, bus8.cout, bus8.sum}),
            64'({1'b1, e8[33], e8[32], e8[7:0]}));
      end
    end
    bus8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_valid_drop", 64'(bus8.out_valid), 64'(0));
    @(negedge clk);
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
